// File: rtl/accum_differentiator.sv
// Recovers per-interval sample totals by differencing successive 20-bit accumulator readings.
// Build option: define ACCUM_DIFF_SAT_EN to clamp results to 16 bits and report clipping on `sat`.
module accum_differentiator #(
    parameter int unsigned DECIM = 1,
    parameter int unsigned SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [19:0] in,
    input  logic        clear,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    output logic        sat
);

    localparam int unsigned IN_W  = 20;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    ref_q, ref_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic [IN_W-1:0]    diff_c;
    logic [OUT_W-1:0]   narrow_c;
    logic               clip_c;
    logic               emit_c;

    // Modulo subtraction absorbs accumulator wrap with no special case.
    assign diff_c = in - ref_q;

`ifdef ACCUM_DIFF_SAT_EN
    logic signed [IN_W-1:0] shifted_c;
    logic                   sat_q, sat_d;

    assign shifted_c = $signed(diff_c) >>> SHIFT;

    always_comb begin
        narrow_c = shifted_c[OUT_W-1:0];
        clip_c   = 1'b0;
        if (shifted_c > $signed(20'h07FFF)) begin
            narrow_c = 16'h7FFF;
            clip_c   = 1'b1;
        end else if (shifted_c < $signed(20'hF8000)) begin
            narrow_c = 16'h8000;
            clip_c   = 1'b1;
        end
    end

    assign sat = sat_q;
`else
    assign narrow_c = OUT_W'($signed(diff_c) >>> SHIFT);
    assign clip_c   = 1'b0;
    assign sat      = 1'b0;
`endif

    // Next-state: priming, decimation count, emission into the output register.
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        emit_c      = 1'b0;
`ifdef ACCUM_DIFF_SAT_EN
        sat_d       = sat_q;
`endif

        if (clear) begin
            state_d     = PRIME;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef ACCUM_DIFF_SAT_EN
            sat_d       = 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end

            if (en) begin
                unique case (state_q)
                    PRIME: begin
                        ref_d   = in;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                    RUN: begin
                        if (cnt_q == CNT_LAST) begin
                            ref_d  = in;
                            cnt_d  = '0;
                            emit_c = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = PRIME;
                endcase
            end

            // A held result is never overwritten; ref/cnt still advance on a drop.
            if (emit_c) begin
                if (!out_valid_q || out_ready) begin
                    out_d       = narrow_c;
                    out_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
`ifdef ACCUM_DIFF_SAT_EN
                if (clip_c) begin
                    sat_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PRIME;
            ref_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef ACCUM_DIFF_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef ACCUM_DIFF_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_accum_differentiator.sv
// Scoreboard bench: two differentiator instances (DECIM=1/SHIFT=0 and DECIM=4/SHIFT=2) on shared stimulus.
module tb_accum_differentiator;

    localparam int D0 = 1;
    localparam int S0 = 0;
    localparam int D1 = 4;
    localparam int S1 = 2;

    logic        clk;
    logic        reset;
    logic        en;
    logic [19:0] in;
    logic        clear;
    logic        out_ready;
    logic [15:0] out_a, out_b;
    logic        valid_a, valid_b;
    logic        ovr_a, ovr_b;
    logic        sat_a, sat_b;

    int n_checks = 0;
    int n_errors = 0;

    accum_differentiator #(.DECIM(D0), .SHIFT(S0)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .in(in), .clear(clear),
        .out(out_a), .out_valid(valid_a), .out_ready(out_ready),
        .overrun(ovr_a), .sat(sat_a)
    );

    accum_differentiator #(.DECIM(D1), .SHIFT(S1)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .in(in), .clear(clear),
        .out(out_b), .out_valid(valid_b), .out_ready(out_ready),
        .overrun(ovr_b), .sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          primed_m [2];
    int          cnt_m    [2];
    logic [19:0] ref_m    [2];
    bit          pend_m   [2];
    bit          ovr_m    [2];
    bit          sat_m    [2];
    logic [15:0] qa [$];
    logic [15:0] qb [$];

    function automatic logic [15:0] model_val(input logic [19:0] d, input int sh, output bit clip);
        int v;
        v = int'(d);
        if (v >= 524288) v = v - 1048576;
        v = v >>> sh;
        clip = 1'b0;
`ifdef ACCUM_DIFF_SAT_EN
        if (v > 32767) begin
            v = 32767;
            clip = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            clip = 1'b1;
        end
`endif
        return 16'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            primed_m[k] = 1'b0;
            cnt_m[k]    = 0;
            pend_m[k]   = 1'b0;
            ovr_m[k]    = 1'b0;
            sat_m[k]    = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic model_step(input int k);
        int          dec, sh;
        bit          clip;
        logic [15:0] v;
        dec = (k == 0) ? D0 : D1;
        sh  = (k == 0) ? S0 : S1;
        if (clear) begin
            primed_m[k] = 1'b0;
            cnt_m[k]    = 0;
            pend_m[k]   = 1'b0;
            ovr_m[k]    = 1'b0;
            sat_m[k]    = 1'b0;
            if (k == 0) qa.delete(); else qb.delete();
            return;
        end
        if (pend_m[k] && out_ready) pend_m[k] = 1'b0;
        if (!en) return;
        if (!primed_m[k]) begin
            primed_m[k] = 1'b1;
            ref_m[k]    = in;
            cnt_m[k]    = 0;
        end else if (cnt_m[k] + 1 < dec) begin
            cnt_m[k]++;
        end else begin
            v = model_val(in - ref_m[k], sh, clip);
            ref_m[k] = in;
            cnt_m[k] = 0;
            if (clip) sat_m[k] = 1'b1;
            if (!pend_m[k]) begin
                pend_m[k] = 1'b1;
                if (k == 0) qa.push_back(v); else qb.push_back(v);
            end else begin
                ovr_m[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- monitor ----------------
    task automatic check_inst(input int k, input logic [15:0] o, input logic v,
                              input logic ov, input logic st);
        logic [15:0] exp_v;
        int          depth;
        chk($sformatf("valid[%0d]", k), int'(v), int'(pend_m[k]));
        chk($sformatf("overrun[%0d]", k), int'(ov), int'(ovr_m[k]));
        chk($sformatf("sat[%0d]", k), int'(st), int'(sat_m[k]));
        if (v === 1'b1) begin
            depth = (k == 0) ? qa.size() : qb.size();
            if (depth == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out[%0d]: got 0x%0h, expected no pending result at %0t", k, o, $time);
            end else begin
                exp_v = (k == 0) ? qa[0] : qb[0];
                chk($sformatf("out[%0d]", k), int'(o), int'(exp_v));
                if (out_ready && !clear && reset) begin
                    if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, out_a, valid_a, ovr_a, sat_a);
        check_inst(1, out_b, valid_b, ovr_b, sat_b);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic e, input logic [19:0] v, input logic c, input logic r);
        en        = e;
        in        = v;
        clear     = c;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [19:0] acc;
    logic [15:0] exp_b;

    initial begin
        reset = 1'b0;
        en = 1'b0; in = '0; clear = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out", int'(out_a), 0);
        chk("rst valid", int'(valid_a), 0);
        chk("rst overrun", int'(ovr_a), 0);
        chk("rst sat", int'(sat_a), 0);
        reset = 1'b1;

        // Basic differencing
        step(1'b1, 20'd0, 1'b0, 1'b1);
        chk("prime no output", int'(valid_a), 0);
        step(1'b1, 20'd100, 1'b0, 1'b1);
        chk("diff +100 valid", int'(valid_a), 1);
        chk("diff +100", int'(out_a), 100);
        step(1'b1, 20'hFFF9C, 1'b0, 1'b1);
        chk("diff -200", int'(out_a), 'hFF38);

        // Accumulator wrap
        step(1'b0, 20'd0, 1'b1, 1'b1);
        step(1'b1, 20'hFFFF0, 1'b0, 1'b1);
        step(1'b1, 20'h00010, 1'b0, 1'b1);
        chk("wrap +32", int'(out_a), 32);
        chk("wrap sat", int'(sat_a), 0);

        // Backpressure drop, then ref advanced past the dropped result
        step(1'b0, 20'd0, 1'b1, 1'b0);
        step(1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b1, 20'd5, 1'b0, 1'b0);
        chk("bp first", int'(out_a), 5);
        step(1'b1, 20'd12, 1'b0, 1'b0);
        chk("bp hold", int'(out_a), 5);
        chk("bp overrun", int'(ovr_a), 1);
        step(1'b0, 20'd12, 1'b0, 1'b1);
        chk("bp drained", int'(valid_a), 0);
        step(1'b1, 20'd21, 1'b0, 1'b1);
        chk("bp after", int'(out_a), 9);

        // Same-cycle accept and load
        step(1'b0, 20'd0, 1'b1, 1'b1);
        step(1'b1, 20'd0, 1'b0, 1'b1);
        step(1'b1, 20'd3, 1'b0, 1'b1);
        step(1'b1, 20'd10, 1'b0, 1'b1);
        chk("same-cycle out", int'(out_a), 7);
        chk("same-cycle valid", int'(valid_a), 1);
        chk("same-cycle overrun", int'(ovr_a), 0);

        // Clear while stalled
        step(1'b0, 20'd10, 1'b0, 1'b1);
        step(1'b1, 20'd20, 1'b0, 1'b0);
        chk("stall out", int'(out_a), 10);
        step(1'b1, 20'd25, 1'b0, 1'b0);
        chk("stall overrun", int'(ovr_a), 1);
        step(1'b0, 20'd0, 1'b1, 1'b0);
        chk("clear valid", int'(valid_a), 0);
        chk("clear overrun", int'(ovr_a), 0);
        step(1'b1, 20'd50, 1'b0, 1'b0);
        chk("clear reprime", int'(valid_a), 0);
        step(1'b1, 20'd55, 1'b0, 1'b1);
        chk("clear next", int'(out_a), 5);

        // Reset while stalled
        step(1'b1, 20'd60, 1'b0, 1'b0);
        chk("pre-reset overrun", int'(ovr_a), 1);
        reset = 1'b0;
        #1;
        chk("reset valid", int'(valid_a), 0);
        chk("reset overrun", int'(ovr_a), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 20'd70, 1'b0, 1'b1);
        chk("reset reprime", int'(valid_a), 0);
        step(1'b1, 20'd75, 1'b0, 1'b1);
        chk("reset next", int'(out_a), 5);

        // Decimate by 4 with shift 2: 0x20000 >>> 2 = 32768 overflows 16 bits
        step(1'b0, 20'd0, 1'b1, 1'b1);
        step(1'b1, 20'd0, 1'b0, 1'b1);
        step(1'b1, 20'd100, 1'b0, 1'b1);
        step(1'b1, 20'd200, 1'b0, 1'b1);
        chk("decim no early", int'(valid_b), 0);
        step(1'b1, 20'd300, 1'b0, 1'b1);
        step(1'b1, 20'h20000, 1'b0, 1'b1);
`ifdef ACCUM_DIFF_SAT_EN
        exp_b = 16'h7FFF;
        chk("decim sat", int'(sat_b), 1);
`else
        exp_b = 16'h8000;
        chk("decim sat", int'(sat_b), 0);
`endif
        chk("decim valid", int'(valid_b), 1);
        chk("decim out", int'(out_b), int'(exp_b));

        // Randomised traffic checked by the scoreboard
        step(1'b0, 20'd0, 1'b1, 1'b1);
        acc = 20'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) acc = 20'($urandom);
            else acc = acc + 20'($urandom_range(0, 20000)) - 20'd10000;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
            step($urandom_range(0, 1) == 1, acc,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
        end
        step(1'b0, acc, 1'b0, 1'b1);
        step(1'b0, acc, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accum_differentiator.md
# accum_differentiator

Reads the running 20-bit sum produced by the sample accumulator and recovers per-interval sample totals by differencing successive accumulator readings, modulo 2^20. Supports optional decimation and scaling. Sits downstream of the accumulator, sharing its `en` strobe. Delivers signed 16-bit results to the consumer over a valid/ready handshake.

## Interface
Parameters:
- DECIM, 1, `en` pulses per output result; legal range 1..16.
- SHIFT, 0, arithmetic right shift applied to the difference before narrowing; legal range 0..4.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  single-cycle pulse; `in` holds a new accumulator value this cycle.
- in  input  20  accumulator value; two's complement, wraps mod 2^20.
- clear  input  1  synchronous restart; returns to PRIME and drops any pending output.
- out  output  16  signed result; stable while `out_valid` is high.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts `out` when high in the same cycle as `out_valid`.
- overrun  output  1  sticky; a result was dropped due to backpressure.
- sat  output  1  sticky; a result was clipped (SAT_EN builds only; tied 0 otherwise).

## Operation
- Registers: `ref` (20b, last reference reading), `cnt` (0..DECIM-1), `out` register, `out_valid`, flags.
- States:
  - PRIME: no reference yet. First `en` loads `ref <= in`, clears `cnt`, moves to RUN. No output is produced.
  - RUN: each `en` increments `cnt`. On the `en` where `cnt == DECIM-1`, an emission occurs:
    - `d = in - ref` mod 2^20, interpreted signed.
    - `s = d >>> SHIFT`, narrowed to 16 bits.
    - `ref <= in`; `cnt <= 0`.
- Emission vs output register:
  - `out_valid == 0`, or `out_ready == 1` in the same cycle: load `out`, set `out_valid`.
  - `out_valid == 1` and `out_ready == 0`: drop the new result, set `overrun`. `ref` and `cnt` still update, so the next interval remains correct.
- Handshake: `out_valid` clears on a cycle with `out_valid && out_ready` unless a new emission loads in that same cycle. `out` never changes while `out_valid && !out_ready`.
- `clear` has priority over `en`. It clears `out_valid`, `cnt`, `overrun`, and `sat`, and goes to PRIME.
- Reset value of every output and register is 0. State after reset is PRIME. Reset asserted mid-handshake drops the pending result.

## Timing
- Latency: the result is registered on the same edge that samples `en`. `out_valid` is high in the following cycle.
- Throughput: one result per cycle when DECIM=1 and `out_ready` is held high.
- An `en` pulse lasting more than one cycle counts as multiple pulses; the upstream guarantees single-cycle pulses.
- Accumulator wrap (for example `ref = 0xFFFF0`, `in = 0x00010`) must yield +32. Modulo subtraction handles this with no special case.
- `overrun` and `sat` assert on the edge of the offending emission and hold until `clear` or reset.

## Configuration
- Macro: ACCUM_DIFF_SAT_EN.
- Defined: `s` is clamped to [-32768, 32767]; any clamp sets `sat`.
- Undefined: `s` is truncated to its low 16 bits (wraps); `sat` is constant 0.

## Test plan
- DECIM=1, SHIFT=0: reset, `en` with in=0, then in=100, then in=0xFFF9C (-100) -> no output after the first pulse, then out=100, then out=-200; `out_ready` held high.
- Wrap: prime with in=0xFFFF0, then `en` with in=0x00010 -> out=32, `sat`=0.
- DECIM=4, SHIFT=0: prime with 0, four `en` pulses ending at in=0x20000 -> with SAT_EN, out=32767 and `sat`=1; without SAT_EN, out=0x0000 and `sat`=0. With SHIFT=2, same input -> out=32767 (131072>>2 = 32768, clamped) / 0x8000 without SAT_EN.
- Backpressure: DECIM=1, `out_ready`=0, emissions of 5 then 7 -> `out` holds 5, `overrun`=1. Raise `out_ready`, then in+9 -> out=9, confirming `ref` advanced past the dropped result.
- Same-cycle accept and load: `out_valid` high with `out_ready`=1 while `en` emits -> new value loaded, `out_valid` stays 1, `overrun` stays 0.
- Reset or `clear` while `out_valid=1` and `out_ready=0` -> `out_valid`=0 and flags=0 next cycle. The next `en` only primes (no output).
